// File: rtl/mux_pkg.sv
// Shared defaults and round-robin helper for the arbitrated output mux.
// Imported by the mux top; the arbiter is self-contained.
package mux_pkg;

  localparam int MUX_WIDTH_DEF = 64;
  localparam int MUX_NIN_DEF   = 4;

  function automatic int rr_next(
    input int ptr,
    input int n
  );
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_mux_reg_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr,
// found by rotating a doubled request vector down by ptr.
module rr_arbiter #(
  parameter  int N_IN  = 4,
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic [N_IN-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_IN-1:0]  grant,
  output logic [IDX_W-1:0] gidx
);

  logic [N_IN-1:0] w_rot;
  logic            w_found;

  assign w_rot = N_IN'({req, req} >> ptr);

  always_comb begin
    grant   = '0;
    gidx    = '0;
    w_found = 1'b0;
    for (int j = 0; j < N_IN; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found = 1'b1;
        gidx    = IDX_W'((int'(ptr) + j) % N_IN);
      end
    end
    if (w_found) begin
      grant = N_IN'(1) << gidx;
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-input round-robin mux feeding a single registered output stage,
// tagging each captured word with the channel it came from.
module rr_mux_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH = MUX_WIDTH_DEF,
  parameter  int N_IN  = MUX_NIN_DEF,
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDX_W-1:0]      out_src,
  input  logic                  out_ready
);

  logic [IDX_W-1:0] r_ptr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [IDX_W-1:0] r_src;

  logic [N_IN-1:0]  w_grant;
  logic [IDX_W-1:0] w_gidx;
  logic             w_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel;

  rr_arbiter #(
    .N_IN (N_IN)
  ) u_arb (
    .req   (in_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .gidx  (w_gidx)
  );

  // Ready is suppressed while in reset so no handshake can complete.
  assign w_load   = ~r_valid | out_ready;
  assign in_ready = w_grant & {N_IN{w_load & reset_n}};
  assign w_xfer   = |(in_valid & in_ready);

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_sel = w_sel | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_sel;
      r_src   <= w_gidx;
      r_ptr   <= IDX_W'(rr_next(int'(w_gidx), N_IN));
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule
